// File: rtl/arb_pkg.sv
// Shared constants and state type for the 16-requester round-robin arbiter.
// Grant index uses the same 8-bit "none" sentinel as the existing priority encoder.
package arb_pkg;

   localparam int         NUM_REQ      = 16;
   localparam int         IDX_W        = 8;
   localparam int         PTR_W        = 4;
   localparam logic [7:0] IDX_NONE     = 8'hF0;
   localparam int         ARB_MAX_HOLD = 255;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate so ptr lands on the top bit, take the
// highest set bit, then map back to the original requester index.
module rr_priority_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   input  logic [NUM_REQ-1:0] mask,
   output logic               found,
   output logic [PTR_W-1:0]   win
);

   logic [NUM_REQ-1:0] eff;
   logic [NUM_REQ-1:0] rot;
   logic [PTR_W-1:0]   k;

   assign eff = req & ~mask;

   // rot[15] is requester ptr, rot[14] is ptr-1, ... wrapping modulo 16
   always_comb begin
      rot = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         rot[j] = eff[PTR_W'(j) + ptr + PTR_W'(1)];
      end
   end

   always_comb begin
      found = 1'b0;
      k     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rot[i]) begin
            found = 1'b1;
            k     = PTR_W'(i);
         end
      end
   end

   assign win = k + ptr + PTR_W'(1);

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for 16 requesters with one-hot and encoded registered grants.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_encoder_arbiter
   import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
   parameter int MAX_HOLD = ARB_MAX_HOLD
)
`endif
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] rel,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout
);

   arb_state_t         state_q, state_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   win;
   logic [NUM_REQ-1:0] mask;
   logic               found;
   logic               owner_holds;
   logic               expire;
   logic               keep;

   assign owner_holds = (state_q == ARB_GRANT) && req[owner_q] && !rel[owner_q];
   assign mask        = (state_q == ARB_GRANT) ? (NUM_REQ'(1) << owner_q) : '0;
   assign keep        = owner_holds && !expire;

   rr_priority_pick u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .mask  (mask),
      .found (found),
      .win   (win)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (!keep) begin
         if (found) begin
            state_d = ARB_GRANT;
            owner_d = win;
            ptr_d   = win - PTR_W'(1);
         end else begin
            state_d = ARB_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         owner_q   <= '0;
         ptr_q     <= PTR_W'(NUM_REQ - 1);
         gnt       <= '0;
         gnt_idx   <= IDX_NONE;
         gnt_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         gnt       <= (state_d == ARB_GRANT) ? (NUM_REQ'(1) << owner_d) : '0;
         gnt_idx   <= (state_d == ARB_GRANT) ? {{(IDX_W-PTR_W){1'b0}}, owner_d} : IDX_NONE;
         gnt_valid <= (state_d == ARB_GRANT);
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_cnt;

   // expire in the MAX_HOLD-th held cycle so the owner sees exactly MAX_HOLD cycles
   assign expire = owner_holds && (hold_cnt == 8'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= expire;
         if (!keep) begin
            hold_cnt <= '0;
         end else if (hold_cnt != 8'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 8'd1;
         end
      end
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed and randomized bench for rr_encoder_arbiter against a behavioural model.
// Define ARB_TIMEOUT_EN to also exercise forced release with MAX_HOLD=4.
module tb_rr_encoder_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int TO_EN = 1;
   localparam int MAXH  = 4;
`else
   localparam int TO_EN = 0;
   localparam int MAXH  = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic [15:0] rel;
   logic [15:0] gnt;
   logic [7:0]  gnt_idx;
   logic        gnt_valid;
   logic        timeout;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: owner -1 means idle
   int m_owner;
   int m_ptr;
   int m_hold;
   bit m_to;

   always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
   rr_encoder_arbiter #(.MAX_HOLD(4)) dut (
`else
   rr_encoder_arbiter dut (
`endif
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .rel       (rel),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic [15:0] r, input logic [15:0] l, input logic rs);
      bit holds, expire, hit;
      int w;
      if (rs) begin
         m_owner = -1; m_ptr = 15; m_hold = 0; m_to = 0;
         return;
      end
      holds  = (m_owner >= 0) && r[m_owner] && !l[m_owner];
      expire = (TO_EN != 0) && holds && (m_hold == MAXH - 1);
      if (holds && !expire) begin
         if (m_hold < MAXH) m_hold++;
         m_to = 0;
      end else begin
         hit = 0;
         w   = 0;
         for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (m_ptr - k + 16) % 16;
            if (!hit && r[idx] && idx != m_owner) begin
               hit = 1;
               w   = idx;
            end
         end
         if (hit) begin
            m_owner = w;
            m_ptr   = (w + 15) % 16;
         end else begin
            m_owner = -1;
         end
         m_hold = 0;
         m_to   = expire;
      end
   endtask

   task automatic step(input logic [15:0] r, input logic [15:0] l, input logic rs);
      logic [15:0] e_gnt;
      logic [7:0]  e_idx;
      req = r;
      rel = l;
      rst = rs;
      model_update(r, l, rs);
      @(posedge clk);
      @(negedge clk);
      e_gnt = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
      e_idx = (m_owner >= 0) ? 8'(m_owner) : 8'hF0;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("gnt_idx", 32'(gnt_idx), 32'(e_idx));
      chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      chk("timeout", 32'(timeout), 32'(m_to));
   endtask

   initial begin
      logic [15:0] r, l;
      int cur;
      rst = 1'b1;
      req = '0;
      rel = '0;
      m_owner = -1; m_ptr = 15; m_hold = 0; m_to = 0;
      @(negedge clk);

      // reset with all requests asserted
      step(16'hFFFF, 16'h0, 1'b1);
      step(16'hFFFF, 16'h0, 1'b1);
      chk("reset_idx", 32'(gnt_idx), 32'hF0);
      chk("reset_valid", 32'(gnt_valid), 32'd0);

      // latency and no-bubble handover
      step(16'h8001, 16'h0, 1'b0);
      chk("lat_idx", 32'(gnt_idx), 32'd15);
      step(16'h8001, 16'h0, 1'b0);
      step(16'h8001, 16'h0, 1'b0);
      step(16'h8001, 16'h8000, 1'b0);
      chk("handover_idx", 32'(gnt_idx), 32'd0);
      chk("handover_valid", 32'(gnt_valid), 32'd1);

      // full rotation
      step(16'h0, 16'h0, 1'b1);
      step(16'hFFFF, 16'h0, 1'b0);
      chk("rot_first", 32'(gnt_idx), 32'd15);
      for (int i = 0; i < 16; i++) begin
         cur = (15 - i + 16) % 16;
         step(16'hFFFF, 16'h1 << cur, 1'b0);
         chk("rot_idx", 32'(gnt_idx), 32'((14 - i + 16) % 16));
         chk("rot_onehot", 32'(gnt), 32'(16'h1 << ((14 - i + 16) % 16)));
      end

      // ignored foreign release, then implicit release by dropping request
      step(16'h0, 16'h0, 1'b1);
      step(16'h0020, 16'h0, 1'b0);
      chk("own5", 32'(gnt_idx), 32'd5);
      step(16'h0020, 16'h0008, 1'b0);
      chk("ignore_rel3", 32'(gnt_idx), 32'd5);
      step(16'h0000, 16'h0, 1'b0);
      chk("drop_idle", 32'(gnt_idx), 32'hF0);

      // reset dominates a simultaneous release
      step(16'h0, 16'h0, 1'b1);
      step(16'h0080, 16'h0, 1'b0);
      chk("own7", 32'(gnt_idx), 32'd7);
      step(16'h0080, 16'h0080, 1'b1);
      chk("rst_mid_idx", 32'(gnt_idx), 32'hF0);
      chk("rst_mid_gnt", 32'(gnt), 32'd0);
      step(16'h0081, 16'h0, 1'b0);
      chk("ptr_restored", 32'(gnt_idx), 32'd7);

`ifdef ARB_TIMEOUT_EN
      step(16'h0, 16'h0, 1'b1);
      step(16'h0003, 16'h0, 1'b0);
      chk("to_own1", 32'(gnt_idx), 32'd1);
      for (int i = 0; i < 3; i++) step(16'h0003, 16'h0, 1'b0);
      chk("to_still1", 32'(gnt_idx), 32'd1);
      step(16'h0003, 16'h0, 1'b0);
      chk("to_own0", 32'(gnt_idx), 32'd0);
      chk("to_pulse", 32'(timeout), 32'd1);
      step(16'h0003, 16'h0, 1'b0);
      chk("to_pulse_end", 32'(timeout), 32'd0);
      for (int i = 0; i < 3; i++) step(16'h0003, 16'h0, 1'b0);
      chk("to_back1", 32'(gnt_idx), 32'd1);
      chk("to_pulse2", 32'(timeout), 32'd1);
`endif

      // randomized traffic against the model
      step(16'h0, 16'h0, 1'b1);
      for (int i = 0; i < 500; i++) begin
         r = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 3) == 0) r = 16'($urandom);
         l = 16'($urandom) & 16'($urandom) & 16'($urandom);
         step(r, l, ($urandom_range(0, 59) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
